// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_e;

    localparam int unsigned ADDR_W_DEF = 23;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MAX_REQ    = 8;

    // First pending index after 'last', wrapping modulo num_req; returns 'last' when nothing is pending.
    function automatic logic [2:0] rr_pick(input logic [7:0] pending, input logic [2:0] last,
                                           input int unsigned num_req);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = (32'(last) + k) % num_req;
            if (k <= num_req && !found && pending[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_arbiter_picker.sv
// Combinational round-robin chooser used by the SDRAM arbiter.
module rr_priority_picker
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   sel_o,
    output logic               any_o
);

    logic [2:0] pick;

    always_comb begin
        pick = rr_pick(8'(pending_i), 3'(last_i), NUM_REQ);
    end

    assign sel_o = IDX_W'(pick);
    assign any_o = |pending_i;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin owner of the single SDRAM port, with optional capped burst lock.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_finished,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      sdram_read,
    output logic                      sdram_write,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic [DATA_W-1:0]         sdram_writedata,
    input  logic [DATA_W-1:0]         sdram_readdata,
    input  logic                      sdram_finished
);

    localparam int unsigned      IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   burst_q, burst_d;

    logic [NUM_REQ-1:0] pending;
    logic [IDX_W-1:0]   sel;
    logic               any_pending;
    logic               g_read, g_write, g_lock, g_pending;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wdata;

    assign pending = req_read | req_write;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .pending_i (pending),
        .last_i    (last_q),
        .sel_o     (sel),
        .any_o     (any_pending)
    );

    // One-hot AND-OR mux: an empty grant yields all zeros rather than X.
    always_comb begin
        g_read    = 1'b0;
        g_write   = 1'b0;
        g_lock    = 1'b0;
        g_pending = 1'b0;
        g_addr    = '0;
        g_wdata   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_read    |= req_read[i];
                g_write   |= req_write[i];
                g_lock    |= req_lock[i];
                g_pending |= pending[i];
                g_addr    |= req_addr[i*ADDR_W +: ADDR_W];
                g_wdata   |= req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        sdram_read      = 1'b0;
        sdram_write     = 1'b0;
        sdram_addr      = '0;
        sdram_writedata = '0;
        req_finished    = '0;
        if (state_q == BUSY) begin
            sdram_write     = g_write;
            sdram_read      = g_read & ~g_write;
            sdram_addr      = g_addr;
            sdram_writedata = g_wdata;
            req_finished    = sdram_finished ? grant_q : '0;
        end
    end

    assign grant        = grant_q;
    assign req_readdata = sdram_readdata;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    grant_d = NUM_REQ'(1) << sel;
                    last_d  = sel;
                    burst_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (sdram_finished) begin
                    state_d = GAP;
                    if (burst_q != BURST_CAP) burst_d = burst_q + 1'b1;
                end
            end
            GAP: begin
                if (g_lock && g_pending && burst_q < BURST_CAP) begin
                    state_d = BUSY;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: requester/controller agent with an in-order issue scoreboard.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int unsigned NR   = 3;
    localparam int unsigned AW   = 23;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_read, req_write, req_lock;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_writedata;
    logic [DW-1:0]     req_readdata;
    logic [NR-1:0]     req_finished, grant;
    logic              sdram_read, sdram_write;
    logic [AW-1:0]     sdram_addr;
    logic [DW-1:0]     sdram_writedata, sdram_readdata;
    logic              sdram_finished;

    sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_lock        (req_lock),
        .req_addr        (req_addr),
        .req_writedata   (req_writedata),
        .req_readdata    (req_readdata),
        .req_finished    (req_finished),
        .grant           (grant),
        .sdram_read      (sdram_read),
        .sdram_write     (sdram_write),
        .sdram_addr      (sdram_addr),
        .sdram_writedata (sdram_writedata),
        .sdram_readdata  (sdram_readdata),
        .sdram_finished  (sdram_finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int unsigned   req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        int            gap;
        int            lat;
    } exp_t;

    txn_t rq[NR][$];
    exp_t exp_q[$];
    txn_t cur_t[NR];
    logic active[NR];
    logic fin_pend[NR];
    int   hold[NR];
    int   start_cyc[NR];
    exp_t cur_e;
    logic ctrl_busy    = 1'b0;
    logic ctrl_hold    = 1'b0;
    logic stray_req    = 1'b0;
    logic stray_active = 1'b0;
    logic abort        = 1'b0;
    int   cyc = 0, lat_cnt = 0, fin_cyc = 0, fin_cnt = 0, issue_cnt = 0;
    int   n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_txn(input int unsigned r, input logic rd, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.rd = rd; t.wr = wr; t.lock = lk; t.addr = a; t.data = d;
        rq[r].push_back(t);
    endtask

    task automatic expect_issue(input int unsigned r, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [DW-1:0] rdat,
                                input int gap, input int lat);
        exp_t e;
        e.req = r; e.wr = wr; e.addr = a; e.data = d; e.rdata = rdat; e.gap = gap; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Agent: requesters and controller are driven 1ns after posedge, outputs sampled on negedge.
    initial begin : agent
        req_read = '0; req_write = '0; req_lock = '0; req_addr = '0; req_writedata = '0;
        sdram_readdata = '0; sdram_finished = 1'b0;
        for (int i = 0; i < NR; i++) begin
            active[i] = 1'b0; fin_pend[i] = 1'b0; hold[i] = 0; start_cyc[i] = 0;
        end
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (abort) begin
                sdram_finished = 1'b0;
                ctrl_busy = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    active[i] = 1'b0; fin_pend[i] = 1'b0; hold[i] = 0;
                    rq[i].delete();
                end
                req_read = '0; req_write = '0; req_lock = '0; req_addr = '0; req_writedata = '0;
            end else begin
                if (sdram_finished) begin
                    sdram_finished = 1'b0;
                    ctrl_busy = 1'b0;
                end else if (ctrl_busy && !ctrl_hold) begin
                    if (lat_cnt > 1) lat_cnt--;
                    else begin
                        sdram_finished = 1'b1;
                        sdram_readdata = cur_e.rdata;
                    end
                end else if (!ctrl_busy && stray_req) begin
                    sdram_finished = 1'b1;
                    sdram_readdata = 32'hDEAD_BEEF;
                    stray_req = 1'b0;
                    stray_active = 1'b1;
                end
                for (int i = 0; i < NR; i++) begin
                    if (fin_pend[i]) begin
                        fin_pend[i] = 1'b0;
                        active[i] = 1'b0;
                    end
                    if (!active[i] && rq[i].size() > 0) begin
                        if (hold[i] > 0) hold[i]--;
                        else begin
                            cur_t[i] = rq[i].pop_front();
                            active[i] = 1'b1;
                            start_cyc[i] = cyc;
                        end
                    end
                    req_read[i]  = active[i] && cur_t[i].rd;
                    req_write[i] = active[i] && cur_t[i].wr;
                    req_lock[i]  = active[i] && cur_t[i].lock;
                    req_addr[i*AW +: AW]      = active[i] ? cur_t[i].addr : '0;
                    req_writedata[i*DW +: DW] = active[i] ? cur_t[i].data : '0;
                end
            end
            @(negedge clk);
            if (sdram_finished && stray_active) begin
                check_eq("stray_fin", req_finished, 0);
                check_eq("stray_grant", grant, 0);
                stray_active = 1'b0;
            end else if (sdram_finished && ctrl_busy) begin
                check_eq("fin_route", req_finished, 1 << cur_e.req);
                if (!cur_e.wr) check_eq("rdata", req_readdata, cur_e.rdata);
                fin_cnt++;
                fin_cyc = cyc;
                fin_pend[cur_e.req] = 1'b1;
            end else if (!ctrl_busy && (sdram_read || sdram_write)) begin
                issue_cnt++;
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur_e = exp_q.pop_front();
                    ctrl_busy = 1'b1;
                    lat_cnt = 1 + (issue_cnt % 3);
                    check_eq("grant", grant, 1 << cur_e.req);
                    check_eq("write", sdram_write, cur_e.wr);
                    check_eq("read", sdram_read, !cur_e.wr);
                    check_eq("addr", sdram_addr, cur_e.addr);
                    check_eq("wdata", sdram_writedata, cur_e.data);
                    if (cur_e.gap >= 0) check_eq("gap", cyc - fin_cyc - 1, cur_e.gap);
                    if (cur_e.lat >= 0) check_eq("lat", cyc - start_cyc[cur_e.req], cur_e.lat);
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int   t;
        logic done;
        t = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            @(negedge clk); #1;
            t++;
            done = (exp_q.size() == 0) && !ctrl_busy && (grant == '0);
            for (int i = 0; i < NR; i++) done = done && !active[i] && (rq[i].size() == 0);
        end
        check_eq(tag, done, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_fin(input int n, input string tag);
        int t;
        t = 0;
        while (fin_cnt < n && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq(tag, fin_cnt >= n, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int issued;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_read", sdram_read, 0);
        check_eq("rst_write", sdram_write, 0);
        check_eq("rst_addr", sdram_addr, 0);
        check_eq("rst_wdata", sdram_writedata, 0);
        check_eq("rst_fin", req_finished, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Contention: 0, 1, 2, then the repeat from 0.
        add_txn(0, 0, 1, 0, 23'h000100, 32'h1111_0000);
        add_txn(0, 0, 1, 0, 23'h000104, 32'h1111_0004);
        add_txn(1, 0, 1, 0, 23'h000200, 32'h2222_0000);
        add_txn(2, 0, 1, 0, 23'h000300, 32'h3333_0000);
        expect_issue(0, 1, 23'h000100, 32'h1111_0000, '0, -1, 1);
        expect_issue(1, 1, 23'h000200, 32'h2222_0000, '0, 2, -1);
        expect_issue(2, 1, 23'h000300, 32'h3333_0000, '0, 2, -1);
        expect_issue(0, 1, 23'h000104, 32'h1111_0004, '0, 2, -1);
        wait_idle("t_contention_done");

        // Single read with GAP/idle observation.
        n = fin_cnt;
        add_txn(0, 1, 0, 0, 23'h000010, '0);
        expect_issue(0, 0, 23'h000010, '0, 32'hABCD_1234, -1, 1);
        wait_fin(n + 1, "t_single_fin");
        @(negedge clk); #1;
        check_eq("t_single_gap_grant", grant, 3'b001);
        check_eq("t_single_gap_read", sdram_read, 0);
        @(negedge clk); #1;
        check_eq("t_single_idle_grant", grant, 0);
        wait_idle("t_single_done");

        // Lock burst of 4 reads while requester 1 waits.
        for (int k = 0; k < 4; k++) begin
            add_txn(0, 1, 0, 1, AW'(k), '0);
            expect_issue(0, 0, AW'(k), '0, 32'hC0DE_0000 + DW'(k), (k == 0) ? -1 : 1, (k == 0) ? 1 : -1);
        end
        hold[1] = 1;
        add_txn(1, 0, 1, 0, 23'h000400, 32'h4444_0000);
        add_txn(1, 0, 1, 0, 23'h000401, 32'h4444_0001);
        expect_issue(1, 1, 23'h000400, 32'h4444_0000, '0, 2, -1);
        expect_issue(1, 1, 23'h000401, 32'h4444_0001, '0, 2, -1);
        wait_idle("t_lock_done");

        // Starvation cap: bursts of MAXB from 0 interleaved with 1.
        hold[1] = 1;
        for (int k = 0; k < 10; k++) add_txn(0, 1, 0, 1, 23'h000500 + AW'(k), '0);
        add_txn(1, 0, 1, 0, 23'h000600, 32'h6666_0000);
        add_txn(1, 0, 1, 0, 23'h000601, 32'h6666_0001);
        for (int k = 0; k < 4; k++)
            expect_issue(0, 0, 23'h000500 + AW'(k), '0, 32'h5000_0000 + DW'(k), (k == 0) ? -1 : 1, (k == 0) ? 1 : -1);
        expect_issue(1, 1, 23'h000600, 32'h6666_0000, '0, 2, -1);
        for (int k = 4; k < 8; k++)
            expect_issue(0, 0, 23'h000500 + AW'(k), '0, 32'h5000_0000 + DW'(k), (k == 4) ? 2 : 1, -1);
        expect_issue(1, 1, 23'h000601, 32'h6666_0001, '0, 2, -1);
        for (int k = 8; k < 10; k++)
            expect_issue(0, 0, 23'h000500 + AW'(k), '0, 32'h5000_0000 + DW'(k), (k == 8) ? 2 : 1, -1);
        wait_idle("t_cap_done");

        // Read and write together: write wins.
        add_txn(2, 1, 1, 0, 23'h7FFFFF, 32'h5A5A_A5A5);
        expect_issue(2, 1, 23'h7FFFFF, 32'h5A5A_A5A5, '0, -1, 1);
        wait_idle("t_rdwr_done");

        // Stray finished while idle.
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("stray_idle_grant", grant, 0);
        check_eq("stray_idle_read", sdram_read, 0);

        // Reset mid-BUSY, then a fresh arbitration starts at requester 0.
        ctrl_hold = 1'b1;
        issued = issue_cnt;
        add_txn(0, 1, 0, 0, 23'h000055, '0);
        expect_issue(0, 0, 23'h000055, '0, '0, -1, 1);
        for (int t = 0; t < 100 && issue_cnt == issued; t++) begin
            @(negedge clk); #1;
        end
        check_eq("t_rst_busy_seen", issue_cnt != issued, 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t_rst_grant", grant, 0);
        check_eq("t_rst_read", sdram_read, 0);
        check_eq("t_rst_write", sdram_write, 0);
        check_eq("t_rst_addr", sdram_addr, 0);
        check_eq("t_rst_wdata", sdram_writedata, 0);
        check_eq("t_rst_fin", req_finished, 0);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        abort = 1'b0;
        ctrl_hold = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk); #1;
        add_txn(0, 1, 0, 0, 23'h000070, '0);
        add_txn(1, 1, 0, 0, 23'h000071, '0);
        expect_issue(0, 0, 23'h000070, '0, 32'h7070_7070, -1, 1);
        expect_issue(1, 0, 23'h000071, '0, 32'h7171_7171, 2, -1);
        wait_idle("t_rst_after_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
